conc_trace_recorder: RTL and testbench

- Output-side companion to the concolic stimulus driver: the driver replays opcodes into DUT inputs, and this block samples the DUT output vector every clock.
- Samples are run-length compressed into an internal trace buffer.
- After recording, the buffer is drained over a valid/ready read port so the concolic engine can reconstruct the per-cycle output trace.
- Sits in the testbench beside the DUT instance; for b06, obs_in = {cc_mux, uscite, enable_count, ackout}.

---
 rtl/conc_trace_recorder_if.sv | 23 ++
 rtl/conc_trace_recorder.sv | 203 ++++++++++++++++++++
 tb/tb_conc_trace_recorder.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conc_trace_recorder_if.sv
// Read-side handshake bundle for the trace recorder.
// The recorder drives valid/data as the master. The concolic engine side
// (or the bench) is the slave and answers with ready.
interface conc_trace_recorder_if #(
    parameter int OBS_W = 6,
    parameter int CNT_W = 8
);
    logic                     rd_valid;
    logic                     rd_ready;
    logic [OBS_W+CNT_W-1:0]   rd_data;

    modport master (
        output rd_valid,
        output rd_data,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        output rd_ready
    );
endinterface

// File: rtl/conc_trace_recorder.sv
// Run-length trace recorder for a DUT output vector.
// Every clock spent in RECORD extends the current run or closes it into the
// trace buffer as {value, run}. After stop (or a buffer overflow) the buffer
// is drained in FIFO order over the valid/ready read port, and the block
// parks in DONE until it is re-armed.
module conc_trace_recorder #(
    parameter int OBS_W = 6,
    parameter int CNT_W = 8,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [OBS_W-1:0]      obs_in,
    conc_trace_recorder_if.master rd,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [AW:0]           entries
);

    localparam int EW = OBS_W + CNT_W;

    localparam logic [CNT_W-1:0] RUN_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] RUN_MAX = {CNT_W{1'b1}};
    localparam logic [AW-1:0]    PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]      CNT_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECORD = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [OBS_W-1:0]  cur_q;
    logic [CNT_W-1:0]  run_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              overflow_q;

    // Trace storage; contents need no reset because count_q gates every read.
    logic [EW-1:0]     mem_q [DEPTH];

    logic              arm;
    logic              in_record;
    logic              extend;
    logic              push_req;
    logic              full;
    logic              push_ok;
    logic              drop;
    logic              has_data;
    logic              pop;

    // A re-arm is honoured from both idle states; stop has no say there.
    assign arm       = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
    assign in_record = (state_q == S_RECORD);

    // The current run keeps growing only while the value repeats and the
    // run field still has headroom; a stop edge never samples obs_in.
    assign extend    = in_record && !stop && (obs_in == cur_q) && (run_q != RUN_MAX);

    // Any other RECORD edge closes the pending run (value change, saturation,
    // or the final flush on stop).
    assign push_req  = in_record && !extend;

    // count_q never exceeds DEPTH and DEPTH is a power of two, so the top bit
    // alone marks a full buffer.
    assign full      = count_q[AW];
    assign push_ok   = push_req && !full;
    assign drop      = push_req && full;

    assign has_data  = (count_q != '0);
    assign pop       = (state_q == S_DRAIN) && has_data && rd.rd_ready;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RECORD;
                end
            end
            S_RECORD: begin
                // A dropped push ends sampling at once, as does stop.
                if (stop || drop) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave only once an edge has seen the buffer empty, so the
                // last entry is presented for a full cycle before DONE.
                if (!has_data) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_RECORD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status and read-port outputs decoded from state and occupancy.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        rd.rd_valid = 1'b0;
        rd.rd_data  = '0;
        unique case (state_q)
            S_RECORD: begin
                busy = 1'b1;
            end
            S_DRAIN: begin
                busy        = 1'b1;
                rd.rd_valid = has_data;
                if (has_data) begin
                    rd.rd_data = mem_q[rd_ptr_q];
                end
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign overflow = overflow_q;
    assign entries  = count_q;

    // Run tracking, pointer and occupancy bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_q      <= '0;
            run_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (arm) begin
            // The start edge is itself the first sample of the trace.
            cur_q      <= obs_in;
            run_q      <= RUN_ONE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (extend) begin
                run_q <= run_q + RUN_ONE;
            end else if (push_ok && !stop) begin
                // Closing a run on a normal edge starts the next one with
                // the value seen on this edge.
                cur_q <= obs_in;
                run_q <= RUN_ONE;
            end

            if (drop) begin
                overflow_q <= 1'b1;
            end

            // Pushes only happen in RECORD and pops only in DRAIN, so the
            // two occupancy updates never collide.
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
                count_q  <= count_q + CNT_ONE;
            end else if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                count_q  <= count_q - CNT_ONE;
            end
        end
    end

    // Buffer write port.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {cur_q, run_q};
        end
    end

endmodule

// File: tb/tb_conc_trace_recorder.sv
`timescale 1ns/1ps
// Directed bench for the run-length trace recorder. A queue-based model of the
// recorder is stepped on every rising edge, and all outputs are compared
// against it on every falling edge. Literal expectations pin the model.
module tb_conc_trace_recorder;

    localparam int OBS_W = 6;
    localparam int CNT_W = 8;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int EW    = OBS_W + CNT_W;
    localparam int RMAX  = (1 << CNT_W) - 1;

    localparam int M_IDLE  = 0;
    localparam int M_REC   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    logic             clock  = 1'b0;
    logic             reset  = 1'b0;
    logic             start  = 1'b0;
    logic             stop   = 1'b0;
    logic [OBS_W-1:0] obs_in = '0;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [AW:0]      entries;

    conc_trace_recorder_if #(.OBS_W(OBS_W), .CNT_W(CNT_W)) rd_if();

    conc_trace_recorder #(
        .OBS_W (OBS_W),
        .CNT_W (CNT_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .obs_in   (obs_in),
        .rd       (rd_if),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .entries  (entries)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Model state: a mode, the open run, the stored entries and a log of
    // every entry handed out on the read port.
    int             m_mode;
    logic [OBS_W-1:0] m_cur;
    int             m_run;
    bit             m_ovf;
    logic [EW-1:0]  m_q[$];
    logic [EW-1:0]  m_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_q.delete();
        m_cur  = '0;
        m_run  = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_step();
        logic [EW-1:0] e;
        if (!reset) begin
            model_reset();
            return;
        end
        case (m_mode)
            M_IDLE, M_DONE: begin
                if (start) begin
                    m_q.delete();
                    m_cur  = obs_in;
                    m_run  = 1;
                    m_ovf  = 1'b0;
                    m_mode = M_REC;
                end
            end
            M_REC: begin
                e = {m_cur, CNT_W'(m_run)};
                if (stop) begin
                    if (m_q.size() < DEPTH) m_q.push_back(e);
                    else m_ovf = 1'b1;
                    m_mode = M_DRAIN;
                end else if (obs_in == m_cur && m_run < RMAX) begin
                    m_run++;
                end else if (m_q.size() == DEPTH) begin
                    m_ovf  = 1'b1;
                    m_mode = M_DRAIN;
                end else begin
                    m_q.push_back(e);
                    m_cur = obs_in;
                    m_run = 1;
                end
            end
            M_DRAIN: begin
                if (m_q.size() == 0) m_mode = M_DONE;
                else if (rd_if.rd_ready) m_log.push_back(m_q.pop_front());
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic compare();
        bit exp_valid;
        exp_valid = (m_mode == M_DRAIN) && (m_q.size() != 0);
        chk("busy",     32'(busy),           32'(m_mode == M_REC || m_mode == M_DRAIN));
        chk("done",     32'(done),           32'(m_mode == M_DONE));
        chk("overflow", 32'(overflow),       32'(m_ovf));
        chk("entries",  32'(entries),        32'(m_q.size()));
        chk("rd_valid", 32'(rd_if.rd_valid), 32'(exp_valid));
        if (exp_valid)
            chk("rd_data", 32'(rd_if.rd_data), 32'(m_q[0]));
    endtask

    // One clock: the model sees the same inputs as the DUT edge, then the
    // outputs are compared half a cycle later.
    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare();
    endtask

    // Drain until done, returning the number of edges after the stop edge.
    task automatic drain_until_done(input bit toggle, output int cyc);
        cyc = 0;
        while (!done && cyc < 200) begin
            rd_if.rd_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            tick();
            cyc++;
        end
        rd_if.rd_ready = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: done=%0b after %0d cycles required 1", done, cyc);
        end
    endtask

    initial begin
        int cyc;
        int first_valid;
        logic [EW-1:0] exp_e;

        rd_if.rd_ready = 1'b0;
        model_reset();

        // Reset state
        tick();
        tick();
        chk("reset_busy",    32'(busy),     32'd0);
        chk("reset_entries", 32'(entries),  32'd0);
        reset = 1'b1;
        tick();

        // Test 1: constant 05 for 10 samples
        m_log.delete();
        obs_in = 6'h05; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        stop = 1'b1; rd_if.rd_ready = 1'b1;
        tick();
        stop = 1'b0;
        drain_until_done(1'b0, cyc);
        $display("t1: stop_to_done=%0d entries_out=%0d overflow=%0b", cyc, m_log.size(), overflow);
        chk("t1_done_latency", 32'(cyc), 32'd2);
        chk("t1_count", 32'(m_log.size()), 32'd1);
        if (m_log.size() == 1) chk("t1_entry", 32'(m_log[0]), 32'h050A);
        chk("t1_overflow", 32'(overflow), 32'd0);

        // Test 2: 05,05,12,12,12,3F
        m_log.delete();
        obs_in = 6'h05; start = 1'b1;
        tick();
        start = 1'b0;
        obs_in = 6'h05; tick();
        obs_in = 6'h12; tick();
        obs_in = 6'h12; tick();
        obs_in = 6'h12; tick();
        obs_in = 6'h3F; tick();
        stop = 1'b1; tick(); stop = 1'b0;
        drain_until_done(1'b0, cyc);
        $display("t2: entries_out=%0d", m_log.size());
        chk("t2_count", 32'(m_log.size()), 32'd3);
        if (m_log.size() == 3) begin
            chk("t2_e0", 32'(m_log[0]), 32'h0502);
            chk("t2_e1", 32'(m_log[1]), 32'h1203);
            chk("t2_e2", 32'(m_log[2]), 32'h3F01);
        end

        // Test 3: 300 samples of 01 saturate the run field once
        m_log.delete();
        obs_in = 6'h01; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 299; i++) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        drain_until_done(1'b0, cyc);
        $display("t3: entries_out=%0d", m_log.size());
        chk("t3_count", 32'(m_log.size()), 32'd2);
        if (m_log.size() == 2) begin
            chk("t3_e0", 32'(m_log[0]), 32'h01FF);
            chk("t3_e1", 32'(m_log[1]), 32'h012D);
        end

        // Test 4: toggling input overflows the buffer
        m_log.delete();
        first_valid = -1;
        obs_in = 6'h2A; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 40; k++) begin
            obs_in = (k % 2 == 1) ? 6'h15 : 6'h2A;
            tick();
            if (first_valid < 0 && rd_if.rd_valid) first_valid = k;
        end
        stop = 1'b1; tick(); stop = 1'b0;
        chk("t4_drain_edge", 32'(first_valid), 32'd33);
        chk("t4_model_ovf", 32'(m_ovf), 32'd1);
        drain_until_done(1'b0, cyc);
        $display("t4: drain_at_edge=%0d entries_out=%0d overflow=%0b", first_valid, m_log.size(), overflow);
        chk("t4_count", 32'(m_log.size()), 32'd32);
        for (int k = 0; k < m_log.size(); k++) begin
            exp_e = (k % 2 == 1) ? 14'h1501 : 14'h2A01;
            chk("t4_entry", 32'(m_log[k]), 32'(exp_e));
        end
        chk("t4_overflow_sticky", 32'(overflow), 32'd1);

        // Test 6: asynchronous reset in the middle of recording
        obs_in = 6'h07; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        obs_in = 6'h09; tick();
        #2 reset = 1'b0;
        #1;
        model_reset();
        compare();
        $display("t6: after reset busy=%0b done=%0b entries=%0d", busy, done, entries);
        chk("t6_busy",     32'(busy),           32'd0);
        chk("t6_valid",    32'(rd_if.rd_valid), 32'd0);
        chk("t6_data",     32'(rd_if.rd_data),  32'd0);
        chk("t6_entries",  32'(entries),        32'd0);
        #1 reset = 1'b1;
        m_log.delete();
        obs_in = 6'h0A; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        stop = 1'b1; tick(); stop = 1'b0;
        drain_until_done(1'b0, cyc);
        $display("t6: rerecord entries_out=%0d overflow=%0b", m_log.size(), overflow);
        chk("t6_count", 32'(m_log.size()), 32'd1);
        if (m_log.size() == 1) chk("t6_entry", 32'(m_log[0]), 32'h0A03);
        chk("t6_overflow", 32'(overflow), 32'd0);

        // Test 5: drain with rd_ready alternating 1,0
        m_log.delete();
        obs_in = 6'h01; start = 1'b1;
        tick();
        start = 1'b0;
        obs_in = 6'h02; tick();
        obs_in = 6'h03; tick();
        obs_in = 6'h04; tick();
        stop = 1'b1; tick(); stop = 1'b0;
        drain_until_done(1'b1, cyc);
        $display("t5: stop_to_done=%0d entries_out=%0d", cyc, m_log.size());
        chk("t5_done_latency", 32'(cyc), 32'd8);
        chk("t5_count", 32'(m_log.size()), 32'd4);
        if (m_log.size() == 4) begin
            chk("t5_e0", 32'(m_log[0]), 32'h0101);
            chk("t5_e1", 32'(m_log[1]), 32'h0201);
            chk("t5_e2", 32'(m_log[2]), 32'h0301);
            chk("t5_e3", 32'(m_log[3]), 32'h0401);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
